dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have st_valid  input  1  retired-store writeback strobe from LSQ (store_wb).
REQ-004 SHALL have st_addr  input  32  store byte address.
REQ-005 SHALL have st_data  input  32  store data (ps2_data).
REQ-006 SHALL have st_sh  input  1  1 = sh, 0 = sw.
REQ-007 SHALL have ld_valid  input  1  load request from LSQ (load_mem).
REQ-008 SHALL have ld_addr / ld_func3 / ld_pd / ld_rob_tag  input  32/3/7/5  load descriptor.
REQ-009 SHALL have ld_ready  output  1  load accepted this cycle when ld_valid && ld_ready.
REQ-010 SHALL have mispredict / mispredict_tag / curr_rob_tag  input  1/5/5  branch flush and ROB window.
REQ-011 SHALL have mem_en / mem_we / mem_addr / mem_wdata / mem_wstrb  output  1/1/32/32/4  single data-memory port.
REQ-012 SHALL have mem_rdata  input  32  read data, valid exactly 1 cycle after a read issue.
REQ-013 SHALL have wb_valid / wb_data / wb_pd / wb_rob_tag  output  1/32/7/5  load result to CDB, one-cycle pulse.
REQ-014 SHALL have sb_full  output  1  store buffer full; LSQ holds retirement of stores while high.

Function
REQ-015 SHALL hold retired stores in a 2-entry in-order FIFO (STBUF_DEPTH=2); st_valid while sb_full is a protocol error and SHALL be ignored.
REQ-016 SHALL run FSM IDLE -> RD_WAIT on read issue; RD_WAIT -> IDLE next cycle with wb_valid=1; store writes SHALL complete in one cycle without leaving IDLE.
REQ-017 In IDLE per cycle, priority: (a) store drain if FIFO full; (b) load if ld_valid and no hazard; (c) store drain if FIFO non-empty; (d) idle.
REQ-018 Hazard: load word address ld_addr[31:2] equal to any valid FIFO entry's addr[31:2] SHALL force ld_ready=0 until that entry drains.
REQ-019 ld_ready SHALL be 1 only in IDLE when rule (b) selects the load; the load is issued to memory in the same cycle (combinational mem_en, mem_we=0, mem_addr={ld_addr[31:2],2'b00}).
REQ-020 Store issue: mem_we=1; sw mem_wstrb=4'b1111; sh mem_wstrb=4'b0011<<(2*addr[1]), data shifted by 16*addr[1]; mem_addr word-aligned.
REQ-021 Load result: lw wb_data=mem_rdata; lbu wb_data={24'b0, byte addr[1:0] of mem_rdata}; other func3 SHALL return 0.
REQ-022 In-flight load (RD_WAIT) SHALL be squashed (no wb_valid, return to IDLE) when mispredict and its rob_tag lies in circular range (mispredict_tag, curr_rob_tag) mod 16.
REQ-023 Mispredict SHALL NOT affect FIFO contents (stores are retired, non-speculative).
REQ-024 Simultaneous st_valid and FIFO drain SHALL keep count unchanged; pointers wrap modulo 2.
REQ-025 sb_full SHALL be registered-count derived (count==2); FIFO enqueue SHALL be accepted in any FSM state.
REQ-026 mem_en SHALL be 0 in RD_WAIT (no store issued while read outstanding).

Reset
REQ-027 On reset, FSM=IDLE, FIFO count/pointers=0, entries cleared, wb_valid=0, wb_data/pd/rob_tag=0, sb_full=0, ld_ready=0, mem_en=0, mem_we=0.
REQ-028 Reset asserted during RD_WAIT SHALL discard the read; no wb_valid after deassertion.

Structure
REQ-029 STBUF_DEPTH, FSM state enum and store-buffer entry struct (addr, data, sh, valid) SHALL live in types_pkg.
REQ-030 The store FIFO SHALL be a sub-module store_buffer (enq, deq, head entry, per-entry address compare outputs).

Verification
REQ-031 Single lw: ld_valid, addr 0x40, memory 0x40=0xDEADBEEF -> ld_ready cycle 0, wb_valid cycle 1, wb_data 0xDEADBEEF.
REQ-032 lbu at 0x43 with word 0x11223344 -> wb_data 0x00000011.
REQ-033 sh to 0x42 data 0x0000ABCD -> mem_wstrb 4'b1100, mem_wdata 0xABCD0000, mem_addr 0x40.
REQ-034 Hazard: buffered sw 0x80=5 plus lw 0x80 same cycle -> store written first, ld_ready next cycle, wb_data 5.
REQ-035 Two stores enqueued then ld_valid -> sb_full=1, store drains before load, then load, then remaining store.
REQ-036 lw rob_tag 7 in RD_WAIT, mispredict_tag 5, curr_rob_tag 10 -> no wb_valid; tag 3 same case -> wb_valid asserted.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the data-memory arbiter: store-buffer sizing, FSM states,
// store-buffer entry layout and the ROB flush-window test.
package types_pkg;

    localparam int STBUF_DEPTH = 2;
    localparam int SB_PTR_W    = 1;
    localparam int SB_CNT_W    = 2;

    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_RD_WAIT = 1'b1
    } fsm_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        sh;
        logic        valid;
    } sb_entry_t;

    // True when tag lies strictly between the mispredicted branch and the ROB tail, mod 16.
    function automatic logic in_flush_range(input logic [4:0] tag,
                                            input logic [4:0] br_tag,
                                            input logic [4:0] tail_tag);
        logic [4:0] d_tag;
        logic [4:0] d_tail;
        d_tag  = (tag - br_tag) & 5'h0F;
        d_tail = (tail_tag - br_tag) & 5'h0F;
        return (d_tag != 5'd0) && (d_tag < d_tail);
    endfunction

endpackage

// File: rtl/store_buffer.sv
// In-order FIFO of retired stores with per-entry word-address match outputs
// used by the arbiter to hold back loads that would read stale memory.
module store_buffer
    import types_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_enq,
    input  logic [31:0]            i_enq_addr,
    input  logic [31:0]            i_enq_data,
    input  logic                   i_enq_sh,
    input  logic                   i_deq,
    input  logic [29:0]            i_cmp_waddr,
    output sb_entry_t              o_head,
    output logic                   o_full,
    output logic [STBUF_DEPTH-1:0] o_hit
);

    logic [SB_PTR_W-1:0] r_wr_ptr;
    logic [SB_PTR_W-1:0] r_rd_ptr;
    logic [SB_CNT_W-1:0] r_count;
    logic                w_do_enq;
    logic                w_do_deq;
    sb_entry_t           w_entries [STBUF_DEPTH];

    // Enqueue while full is dropped: the LSQ must not retire a store against sb_full.
    assign o_full   = (r_count == SB_CNT_W'(STBUF_DEPTH));
    assign w_do_enq = i_enq && !o_full;
    assign w_do_deq = i_deq && o_head.valid;
    assign o_head   = w_entries[r_rd_ptr];

    generate
        for (genvar gi = 0; gi < STBUF_DEPTH; gi++) begin : g_entry
            sb_entry_t r_entry;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_entry <= '0;
                end else if (w_do_enq && (r_wr_ptr == SB_PTR_W'(gi))) begin
                    r_entry <= '{addr: i_enq_addr, data: i_enq_data, sh: i_enq_sh, valid: 1'b1};
                end else if (w_do_deq && (r_rd_ptr == SB_PTR_W'(gi))) begin
                    r_entry.valid <= 1'b0;
                end
            end

            assign w_entries[gi] = r_entry;
            assign o_hit[gi]     = r_entry.valid && (r_entry.addr[31:2] == i_cmp_waddr);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_enq, w_do_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: drains retired stores from a small buffer and
// issues loads, returning load results to the CDB one cycle after issue.
module dmem_arbiter
    import types_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic        st_sh,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_func3,
    input  logic [6:0]  ld_pd,
    input  logic [4:0]  ld_rob_tag,
    output logic        ld_ready,
    input  logic        mispredict,
    input  logic [4:0]  mispredict_tag,
    input  logic [4:0]  curr_rob_tag,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [6:0]  wb_pd,
    output logic [4:0]  wb_rob_tag,
    output logic        sb_full
);

    fsm_state_e             r_state;
    logic [6:0]             r_ld_pd;
    logic [4:0]             r_ld_rob_tag;
    logic [2:0]             r_ld_func3;
    logic [1:0]             r_ld_byte;
    sb_entry_t              w_head;
    logic                   w_full;
    logic [STBUF_DEPTH-1:0] w_hit;
    logic                   w_idle;
    logic                   w_hazard;
    logic                   w_ld_go;
    logic                   w_drain;
    logic                   w_squash;

    store_buffer u_store_buffer (
        .clk         (clk),
        .reset       (reset),
        .i_enq       (st_valid),
        .i_enq_addr  (st_addr),
        .i_enq_data  (st_data),
        .i_enq_sh    (st_sh),
        .i_deq       (w_drain),
        .i_cmp_waddr (ld_addr[31:2]),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_hit       (w_hit)
    );

    // A store being retired this very cycle is older than the load, so it also blocks it.
    assign w_hazard = (|w_hit) || (st_valid && !w_full && (st_addr[31:2] == ld_addr[31:2]));
    assign w_idle   = (r_state == S_IDLE) && !reset;
    assign w_ld_go  = w_idle && !w_full && ld_valid && !w_hazard;
    assign w_drain  = w_idle && w_head.valid && !w_ld_go;
    assign ld_ready = w_ld_go;
    assign sb_full  = w_full;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (w_ld_go) begin
            mem_en   = 1'b1;
            mem_addr = ld_addr & ~32'h3;
        end else if (w_drain) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = w_head.addr & ~32'h3;
            if (w_head.sh) begin
                mem_wstrb = w_head.addr[1] ? 4'b1100 : 4'b0011;
                mem_wdata = w_head.addr[1] ? {w_head.data[15:0], 16'h0000} : w_head.data;
            end else begin
                mem_wstrb = 4'b1111;
                mem_wdata = w_head.data;
            end
        end
    end

    assign w_squash = mispredict && in_flush_range(r_ld_rob_tag, mispredict_tag, curr_rob_tag);
    assign wb_valid = (r_state == S_RD_WAIT) && !w_squash;

    always_comb begin
        wb_data    = '0;
        wb_pd      = '0;
        wb_rob_tag = '0;
        if (wb_valid) begin
            wb_pd      = r_ld_pd;
            wb_rob_tag = r_ld_rob_tag;
            case (r_ld_func3)
                F3_LW:   wb_data = mem_rdata;
                F3_LBU:  wb_data = {24'h000000, mem_rdata[8*r_ld_byte +: 8]};
                default: wb_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ld_pd      <= '0;
            r_ld_rob_tag <= '0;
            r_ld_func3   <= '0;
            r_ld_byte    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ld_go) begin
                        r_state      <= S_RD_WAIT;
                        r_ld_pd      <= ld_pd;
                        r_ld_rob_tag <= ld_rob_tag;
                        r_ld_func3   <= ld_func3;
                        r_ld_byte    <= ld_addr[1:0];
                    end
                end
                S_RD_WAIT: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
